// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with doubleword bus handshake
//
// Purpose: accepts one LDUR/STUR-family request at a time. It drives a
// req/ack doubleword memory bus with byte-lane write strobes, and returns
// sign- or zero-extended load data.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus access that has
// waited TIMEOUT_CYCLES cycles without bus_ack.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_write/req_size  request pulse, store flag, access size
//   req_signed                    load extension mode
//   address, write_data           effective address, right-justified store data
//   bus_req/bus_we/bus_addr       memory bus request, write enable, aligned address
//   bus_wdata/bus_wstrb           lane-shifted store data, byte strobes
//   bus_ack/bus_rdata             memory completion and read doubleword
//   read_data                     extended load result
//   done/fault/busy               completion pulse, error pulse, stall
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  output logic [63:0] read_data,
  output logic        done,
  output logic        fault,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_next;

  logic [2:0]  lane;
  logic        misaligned;
  logic        accept;
  logic [7:0]  strobe;
  logic [2:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [63:0] shifted_rdata;
  logic [63:0] load_value;
  logic        timeout;

  assign lane   = address[2:0];
  assign accept = (state == IDLE) && req_valid;
  assign busy   = (state != IDLE);

  always_comb begin
    misaligned = 1'b0;
    strobe     = 8'h00;
    case (req_size)
      2'b00: strobe = 8'h01 << lane;
      2'b01: begin
        misaligned = address[0];
        strobe     = 8'h03 << lane;
      end
      2'b10: begin
        misaligned = |address[1:0];
        strobe     = 8'h0F << lane;
      end
      default: begin
        misaligned = |address[2:0];
        strobe     = 8'hFF;
      end
    endcase
  end

  // The lane, size and sign mode are taken from the values captured at acceptance.
  always_comb begin
    shifted_rdata = bus_rdata >> {lane_q, 3'b000};
    load_value    = shifted_rdata;
    case (size_q)
      2'b00: load_value = {{56{signed_q & shifted_rdata[7]}},  shifted_rdata[7:0]};
      2'b01: load_value = {{48{signed_q & shifted_rdata[15]}}, shifted_rdata[15:0]};
      2'b10: load_value = {{32{signed_q & shifted_rdata[31]}}, shifted_rdata[31:0]};
      default: load_value = shifted_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !bus_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // An ack in the limit cycle takes priority, so the completion is normal.
  assign timeout = (state == WAIT) && !bus_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid && !misaligned) state_next = WAIT;
      WAIT: if (bus_ack || timeout)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 64'd0;
      bus_wdata <= 64'd0;
      bus_wstrb <= 8'h00;
      read_data <= 64'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
      lane_q    <= 3'd0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      if (accept) begin
        if (misaligned) begin
          done  <= 1'b1;
          fault <= 1'b1;
        end else begin
          bus_req   <= 1'b1;
          bus_we    <= req_write;
          bus_addr  <= {address[63:3], 3'b000};
          bus_wdata <= write_data << {lane, 3'b000};
          bus_wstrb <= req_write ? strobe : 8'h00;
          lane_q    <= lane;
          size_q    <= req_size;
          signed_q  <= req_signed;
        end
      end else if (state == WAIT) begin
        if (bus_ack) begin
          bus_req <= 1'b0;
          done    <= 1'b1;
          if (!bus_we) read_data <= load_value;
        end else if (timeout) begin
          bus_req <= 1'b0;
          done    <= 1'b1;
          fault   <= 1'b1;
        end
      end
    end
  end

endmodule
